sum_result_collector: RTL and testbench

- Downstream consumer of the adder stage. Captures every one-cycle `valid` / `y` result pulse into a small show-ahead FIFO.
- Presents buffered results to the next consumer over a valid/ready handshake.
- Keeps a saturating running total of all accepted results and a saturating count of dropped results.
- The adder has no backpressure, so overflow is handled by dropping, never by stalling upstream.

---
 rtl/sum_result_collector.sv | 181 ++++++++++++++++++
 tb/tb_sum_result_collector.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_result_collector.sv
// -----------------------------------------------------------------------------
// sum_result_collector
//
// Purpose:
//   Sits after the adder stage. Every one-cycle in_valid/in_data result pulse is
//   written into a small show-ahead FIFO. Buffered results go to the next
//   consumer over a valid/ready handshake. The adder cannot be stalled, so a
//   result that finds the FIFO full is dropped and counted. The block also
//   keeps a saturating running total of all accepted results.
//
// Parameters:
//   W      result data width
//   DEPTH  FIFO entries (power of 2, >= 2)
//   ACC_W  running-total width (> W)
//   CW     occupancy count width, derived from DEPTH (do not override)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   result strobe from the adder
//   in_data    result value from the adder
//   out_valid  head entry available (show-ahead)
//   out_ready  consumer takes the head entry this cycle
//   out_data   head entry value, 0 when empty
//   acc_clear  clear the running total
//   acc        saturating sum of accepted results
//   acc_sat    sticky flag: acc has saturated since the last clear/reset
//   count      current occupancy, 0..DEPTH
//   full       count == DEPTH
//   empty      count == 0
//   drop_cnt   saturating count of dropped results
//   out_par    (parity build only) stored even parity of the head entry
//
// Optional feature:
//   Define SUM_RESULT_COLLECTOR_PARITY_EN to store a parity bit with every
//   entry and expose it on out_par.
// -----------------------------------------------------------------------------
module sum_result_collector #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int ACC_W = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  input  logic             acc_clear,
  output logic [ACC_W-1:0] acc,
  output logic             acc_sat,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic [7:0]       drop_cnt
`ifdef SUM_RESULT_COLLECTOR_PARITY_EN
  ,
  output logic             out_par
`endif
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             acc_sat_q, acc_sat_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;
  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
`ifdef SUM_RESULT_COLLECTOR_PARITY_EN
  logic             par_q [DEPTH];
  logic             par_d [DEPTH];
`endif

  logic             pop;
  logic             accept;
  logic [ACC_W:0]   sum;  // one carry bit wider to detect saturation

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign out_valid = !empty;
  assign out_data  = empty ? '0 : mem_q[rd_ptr_q];
  assign count     = count_q;
  assign acc       = acc_q;
  assign acc_sat   = acc_sat_q;
  assign drop_cnt  = drop_cnt_q;
`ifdef SUM_RESULT_COLLECTOR_PARITY_EN
  assign out_par   = empty ? 1'b0 : par_q[rd_ptr_q];
`endif

  // A pop frees a slot in the same cycle, so a full FIFO still accepts.
  assign pop    = out_valid && out_ready;
  assign accept = in_valid && (!full || pop);
  assign sum    = {1'b0, acc_q} + (ACC_W + 1)'(in_data);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    acc_d      = acc_q;
    acc_sat_d  = acc_sat_q;
    drop_cnt_d = drop_cnt_q;
    mem_d      = mem_q;
`ifdef SUM_RESULT_COLLECTOR_PARITY_EN
    par_d      = par_q;
`endif

    // Pointers are exactly log2(DEPTH) bits, so incrementing wraps
    // DEPTH-1 back to 0 by itself.
    if (accept) begin
      mem_d[wr_ptr_q] = in_data;
`ifdef SUM_RESULT_COLLECTOR_PARITY_EN
      par_d[wr_ptr_q] = ^in_data;
`endif
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    unique case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (in_valid && !accept && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end

    // A clear in the same cycle as an accept restarts the total from
    // this result, not from zero.
    if (acc_clear) begin
      acc_d     = accept ? ACC_W'(in_data) : '0;
      acc_sat_d = 1'b0;
    end else if (accept) begin
      if (sum[ACC_W]) begin
        acc_d     = '1;
        acc_sat_d = 1'b1;
      end else begin
        acc_d = sum[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops
    // update together from values sampled at the same edge.
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      acc_q      <= '0;
      acc_sat_q  <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      acc_q      <= acc_d;
      acc_sat_q  <= acc_sat_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // NOTE: storage is deliberately not reset; stale entries are never visible
  // because out_data/out_par are forced to 0 while empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
`ifdef SUM_RESULT_COLLECTOR_PARITY_EN
    par_q <= par_d;
`endif
  end

endmodule

// File: tb/tb_sum_result_collector.sv
// -----------------------------------------------------------------------------
// tb_sum_result_collector
//
// Self-checking bench for sum_result_collector (W=8, DEPTH=4, ACC_W=16).
// A reference model (queue + integer total + drop counter) tracks the
// expected state; after every clock the DUT outputs are compared against it.
// Directed scenarios are followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_sum_result_collector;

  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int ACC_W = 16;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int ACC_MAX = (1 << ACC_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [W-1:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic             acc_clear;
  logic [ACC_W-1:0] acc;
  logic             acc_sat;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic [7:0]       drop_cnt;
`ifdef SUM_RESULT_COLLECTOR_PARITY_EN
  logic             out_par;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [W-1:0] mq[$];
  int           macc;
  bit           msat;
  int           mdrop;

  sum_result_collector #(.W(W), .DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .acc_clear (acc_clear),
    .acc       (acc),
    .acc_sat   (acc_sat),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .drop_cnt  (drop_cnt)
`ifdef SUM_RESULT_COLLECTOR_PARITY_EN
    ,
    .out_par   (out_par)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    logic [W-1:0] front;
    front = (mq.size() != 0) ? mq[0] : '0;
    check({tag, ".out_valid"}, 32'(out_valid), 32'(mq.size() != 0));
    check({tag, ".empty"},     32'(empty),     32'(mq.size() == 0));
    check({tag, ".full"},      32'(full),      32'(mq.size() == DEPTH));
    check({tag, ".count"},     32'(count),     32'(mq.size()));
    check({tag, ".out_data"},  32'(out_data),  32'(front));
    check({tag, ".acc"},       32'(acc),       32'(macc));
    check({tag, ".acc_sat"},   32'(acc_sat),   32'(msat));
    check({tag, ".drop_cnt"},  32'(drop_cnt),  32'(mdrop));
`ifdef SUM_RESULT_COLLECTOR_PARITY_EN
    check({tag, ".out_par"},   32'(out_par),   32'(^front));
`endif
  endtask

  // Apply one cycle of inputs, advance the model by the behavioural rules,
  // clock the DUT and compare everything #1 after the edge.
  task automatic cycle(input string tag, input bit v, input logic [W-1:0] d,
                       input bit rdy, input bit clr, input bit r);
    bit pop;
    bit acc_ok;
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    acc_clear = clr;
    rst       = r;
    if (r) begin
      mq.delete();
      macc  = 0;
      msat  = 0;
      mdrop = 0;
    end else begin
      pop    = (mq.size() != 0) && rdy;
      acc_ok = v && ((mq.size() < DEPTH) || pop);
      if (clr) begin
        macc = acc_ok ? int'(d) : 0;
        msat = 0;
      end else if (acc_ok) begin
        if (macc + int'(d) > ACC_MAX) begin
          macc = ACC_MAX;
          msat = 1;
        end else begin
          macc = macc + int'(d);
        end
      end
      if (v && !acc_ok && mdrop < 255) mdrop++;
      if (pop) void'(mq.pop_front());
      if (acc_ok) mq.push_back(d);
    end
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  initial begin
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    acc_clear = 1'b0;
    rst       = 1'b1;
    mq.delete();
    macc  = 0;
    msat  = 0;
    mdrop = 0;

    // Power-on reset
    cycle("por", 0, 8'h00, 0, 0, 1);
    cycle("por", 0, 8'h00, 0, 0, 1);
    check("por.out_valid", 32'(out_valid), 32'd0);
    check("por.empty",     32'(empty),     32'd1);
    check("por.out_data",  32'(out_data),  32'd0);

    // 1. Reset mid-stream with 2 entries, drop_cnt=1, acc=0x30
    cycle("t1.push", 1, 8'h10, 0, 0, 0);
    cycle("t1.push", 1, 8'h10, 0, 0, 0);
    cycle("t1.push", 1, 8'h08, 0, 0, 0);
    cycle("t1.push", 1, 8'h08, 0, 0, 0);
    cycle("t1.drop", 1, 8'h01, 0, 0, 0);
    cycle("t1.pop",  0, 8'h00, 1, 0, 0);
    cycle("t1.pop",  0, 8'h00, 1, 0, 0);
    check("t1.pre_count", 32'(count),    32'd2);
    check("t1.pre_drop",  32'(drop_cnt), 32'd1);
    check("t1.pre_acc",   32'(acc),      32'h30);
    cycle("t1.rst", 1, 8'h55, 1, 0, 1);   // result in reset cycle is ignored
    check("t1.count",    32'(count),     32'd0);
    check("t1.out_valid",32'(out_valid), 32'd0);
    check("t1.acc",      32'(acc),       32'd0);
    check("t1.drop",     32'(drop_cnt),  32'd0);

    // 2. Ordering
    cycle("t2.push", 1, 8'h12, 0, 0, 0);
    cycle("t2.push", 1, 8'h34, 0, 0, 0);
    cycle("t2.push", 1, 8'hFF, 0, 0, 0);
    cycle("t2.hold", 0, 8'h00, 0, 0, 0);
    check("t2.count", 32'(count),    32'd3);
    check("t2.acc",   32'(acc),      32'h145);
    check("t2.head0", 32'(out_data), 32'h12);
    cycle("t2.pop", 0, 8'h00, 1, 0, 0);
    check("t2.head1", 32'(out_data), 32'h34);
    cycle("t2.pop", 0, 8'h00, 1, 0, 0);
    check("t2.head2", 32'(out_data), 32'hFF);
    cycle("t2.pop", 0, 8'h00, 1, 0, 0);
    check("t2.empty",    32'(empty),    32'd1);
    check("t2.out_data", 32'(out_data), 32'd0);
    cycle("t2.idle_rdy", 0, 8'h00, 1, 0, 0);  // ready while empty: no effect

    // 3. Overflow drop
    cycle("t3.clr", 0, 8'h00, 0, 1, 0);
    for (int i = 1; i <= 4; i++) cycle("t3.push", 1, 8'(i), 0, 0, 0);
    check("t3.full", 32'(full), 32'd1);
    cycle("t3.drop", 1, 8'h05, 0, 0, 0);
    check("t3.drop_cnt", 32'(drop_cnt), 32'd1);
    check("t3.count",    32'(count),    32'd4);
    check("t3.acc",      32'(acc),      32'h0A);
    check("t3.head",     32'(out_data), 32'h01);

    // 4. Full with simultaneous pop
    cycle("t4.pushpop", 1, 8'h77, 1, 0, 0);
    check("t4.count",    32'(count),    32'd4);
    check("t4.drop_cnt", 32'(drop_cnt), 32'd1);
    check("t4.head0",    32'(out_data), 32'h02);
    cycle("t4.pop", 0, 8'h00, 1, 0, 0);
    check("t4.head1", 32'(out_data), 32'h03);
    cycle("t4.pop", 0, 8'h00, 1, 0, 0);
    check("t4.head2", 32'(out_data), 32'h04);
    cycle("t4.pop", 0, 8'h00, 1, 0, 0);
    check("t4.head3", 32'(out_data), 32'h77);
    cycle("t4.pop", 0, 8'h00, 1, 0, 0);
    check("t4.empty", 32'(empty), 32'd1);

    // 5. Saturation
    cycle("t5.clr", 0, 8'h00, 1, 1, 0);
    for (int i = 0; i < 257; i++) cycle("t5.push", 1, 8'hFF, 1, 0, 0);
    check("t5.acc257", 32'(acc),     32'hFFFF);
    check("t5.sat257", 32'(acc_sat), 32'd0);
    cycle("t5.push258", 1, 8'hFF, 1, 0, 0);
    check("t5.acc258", 32'(acc),     32'hFFFF);
    check("t5.sat258", 32'(acc_sat), 32'd1);
    cycle("t5.clr", 0, 8'h00, 0, 1, 0);
    check("t5.acc_clr", 32'(acc),     32'd0);
    check("t5.sat_clr", 32'(acc_sat), 32'd0);

    // 6. Clear together with an accept
    cycle("t6.push", 1, 8'h80, 0, 0, 0);
    cycle("t6.push", 1, 8'h80, 0, 0, 0);
    check("t6.acc_pre",   32'(acc),   32'h100);
    check("t6.count_pre", 32'(count), 32'd3);
    cycle("t6.clradd", 1, 8'h09, 0, 1, 0);
    check("t6.acc",   32'(acc),   32'h09);
    check("t6.count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) cycle("t6.drain", 0, 8'h00, 1, 0, 0);
    cycle("t6.par7", 1, 8'h07, 0, 0, 0);
`ifdef SUM_RESULT_COLLECTOR_PARITY_EN
    check("t6.out_par7", 32'(out_par), 32'd1);
`endif
    cycle("t6.pop", 0, 8'h00, 1, 0, 0);
    cycle("t6.par3", 1, 8'h03, 0, 0, 0);
`ifdef SUM_RESULT_COLLECTOR_PARITY_EN
    check("t6.out_par3", 32'(out_par), 32'd0);
`endif
    cycle("t6.pop", 0, 8'h00, 1, 0, 0);

    // Randomized phase
    for (int i = 0; i < 2000; i++) begin
      bit           v;
      bit           rdy;
      bit           clr;
      bit           r;
      logic [W-1:0] d;
      v   = ($urandom_range(0, 9) < 7);
      rdy = ($urandom_range(0, 1) == 1);
      clr = ($urandom_range(0, 199) == 0);
      r   = ($urandom_range(0, 99) == 0);
      d   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(240, 255))
                                        : 8'($urandom);
      cycle("rand", v, d, rdy, clr, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
